// File: rtl/mips32_muldiv_unit.sv
// mips32_muldiv_unit: iterative one-bit-per-cycle signed/unsigned multiply/divide with HI/LO results and flush
module mips32_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, hi_q, hi_d, lo_q, lo_d;
  logic [1:0] op_q;
  logic sa_q, sb_q, dz_q, done_q, sgn_a, sgn_b, last, load, fire, dz, neg;
  logic [WIDTH:0] sum, t, diff;
  logic [2*WIDTH-1:0] prod;
  assign last = cnt_q == CW'(WIDTH - 1);
  assign load = state_q == IDLE && start_i && !flush_i;
  assign fire = state_q == FIX && !flush_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (load ? RUN : IDLE)
            : flush_i ? IDLE
            : state_q == RUN ? (last ? FIX : RUN) : IDLE;
  always_comb begin
    busy_o = state_q != IDLE;
    done_o = done_q;
    hi_o = hi_q;
    lo_o = lo_q;
    div_by_zero_o = dz_q;
  end
  // acc holds the running high half (multiply) or partial remainder (divide); q shifts multiplier out / quotient in
  always_comb begin
    sgn_a = op_i[0] && a_i[WIDTH-1];
    sgn_b = op_i[0] && b_i[WIDTH-1];
    sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    t = {acc_q, q_q[WIDTH-1]};
    diff = t - {1'b0, m_q};
    {acc_d, q_d} = op_q[1] ? {diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0], q_q[WIDTH-2:0], ~diff[WIDTH]}
                           : {sum, q_q[WIDTH-1:1]};
    neg = sa_q ^ sb_q;
    dz = op_q[1] && m_q == '0;
    prod = neg ? -{acc_q, q_q} : {acc_q, q_q};
    // a zero divisor leaves |a| as remainder, so the dividend sign fix restores a exactly
    hi_d = op_q[1] ? (sa_q ? -acc_q : acc_q) : prod[2*WIDTH-1:WIDTH];
    lo_d = op_q[1] ? (dz ? '1 : neg ? -q_q : q_q) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt_q <= '0;
      acc_q <= '0;
      q_q <= '0;
      m_q <= '0;
      op_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      dz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fire;
      if (load) begin
        op_q <= op_i;
        sa_q <= sgn_a;
        sb_q <= sgn_b;
        acc_q <= '0;
        q_q <= sgn_a ? -a_i : a_i;
        m_q <= sgn_b ? -b_i : b_i;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        acc_q <= acc_d;
        q_q <= q_d;
        cnt_q <= cnt_q + CW'(1);
      end
      if (fire) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
        dz_q <= dz;
      end
    end
endmodule

// File: tb/tb_mips32_muldiv_unit.sv
// tb_mips32_muldiv_unit: directed vectors into a scoreboard, checked by per-instance done monitors (WIDTH 32 and 8)
module tb_mips32_muldiv_unit;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;
  logic clk = 0, rst = 1;
  logic start32 = 0, flush32 = 0, start8 = 0, flush8 = 0;
  logic [1:0] op32 = 0, op8 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic busy32, done32, dz32, busy8, done8, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0] hi8, lo8;
  int cyc = 0, checks = 0, errors = 0, bc32 = 0, bc8 = 0;
  int fm[6] = '{7, 6, 5, 4, 3, 2};
  int fp[6] = '{7, 42, 210, 840, 2520, 5040};
  exp_t q32[$], q8[$], e32, e8;

  mips32_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .start_i(start32), .op_i(op32), .a_i(a32), .b_i(b32),
    .flush_i(flush32), .busy_o(busy32), .done_o(done32), .hi_o(hi32), .lo_o(lo32),
    .div_by_zero_o(dz32));
  mips32_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .op_i(op8), .a_i(a8), .b_i(b8),
    .flush_i(flush8), .busy_o(busy8), .done_o(done8), .hi_o(hi8), .lo_o(lo8),
    .div_by_zero_o(dz8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done32) begin
      chk("busy_len32", bc32, 33);
      bc32 = 0;
      if (q32.size() == 0) chk("spurious_done32", 32'(done32), 0);
      else begin
        e32 = q32.pop_front();
        chk("hi32", hi32, e32.hi);
        chk("lo32", lo32, e32.lo);
        chk("dz32", 32'(dz32), 32'(e32.dz));
        chk("latency32", cyc, e32.cyc);
      end
    end else bc32 = busy32 ? bc32 + 1 : 0;
  end

  always @(negedge clk) begin
    if (done8) begin
      chk("busy_len8", bc8, 9);
      bc8 = 0;
      if (q8.size() == 0) chk("spurious_done8", 32'(done8), 0);
      else begin
        e8 = q8.pop_front();
        chk("hi8", 32'(hi8), e8.hi);
        chk("lo8", 32'(lo8), e8.lo);
        chk("dz8", 32'(dz8), 32'(e8.dz));
        chk("latency8", cyc, e8.cyc);
      end
    end else bc8 = busy8 ? bc8 + 1 : 0;
  end

  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input bit push);
    op32 = op;
    a32 = a;
    b32 = b;
    start32 = 1;
    if (push) q32.push_back('{ehi, elo, edz, cyc + 34});
    @(negedge clk);
    start32 = 0;
  endtask

  task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    op8 = op;
    a8 = a;
    b8 = b;
    start8 = 1;
    q8.push_back('{ehi, elo, edz, cyc + 10});
    @(negedge clk);
    start8 = 0;
  endtask

  task automatic wait_done32();
    int n = 0;
    while (!done32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done32_seen", 32'(done32), 1);
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done8_seen", 32'(done8), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hi32", hi32, 0);
    chk("rst_lo32", lo32, 0);
    chk("rst_busy32", 32'(busy32), 0);
    chk("rst_done32", 32'(done32), 0);
    chk("rst_dz32", 32'(dz32), 0);
    chk("rst_lo8", 32'(lo8), 0);
    rst = 0;
    @(negedge clk);
    issue32(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 1);
    wait_done32();
    issue32(2'b01, -32'sd7, 32'd6, 32'hFFFFFFFF, 32'hFFFFFFD6, 0, 1);
    wait_done32();
    for (int i = 0; i < 6; i++) begin
      issue32(2'b00, i == 0 ? 32'd1 : fp[i-1], fm[i], 32'd0, fp[i], 0, 1);
      wait_done32();
    end
    issue32(2'b11, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1);
    wait_done32();
    issue32(2'b10, 32'd200, 32'd7, 32'd4, 32'd28, 0, 1);
    wait_done32();
    issue32(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0, 1);
    wait_done32();
    issue32(2'b10, 32'd200, 32'd0, 32'd200, 32'hFFFFFFFF, 1, 1);
    wait_done32();
    issue32(2'b11, -32'sd7, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1, 1);
    wait_done32();
    issue32(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 0, 1);
    wait_done32();
    issue32(2'b00, 32'd5, 32'd5, 32'd0, 32'd0, 0, 0);
    repeat (9) @(negedge clk);
    flush32 = 1;
    @(negedge clk);
    flush32 = 0;
    chk("flush_busy32", 32'(busy32), 0);
    chk("flush_hi32", hi32, 0);
    chk("flush_lo32", lo32, 12);
    repeat (40) @(negedge clk);
    chk("flush_lo32_later", lo32, 12);
    op32 = 2'b00;
    a32 = 1;
    b32 = 1;
    start32 = 1;
    flush32 = 1;
    @(negedge clk);
    start32 = 0;
    flush32 = 0;
    chk("startflush_busy32", 32'(busy32), 0);
    @(negedge clk);
    chk("startflush_busy32_b", 32'(busy32), 0);
    issue32(2'b11, 32'd100, 32'd3, 32'd0, 32'd0, 0, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_lo32", lo32, 0);
    chk("arst_hi32", hi32, 0);
    chk("arst_busy32", 32'(busy32), 0);
    #1 rst = 0;
    @(negedge clk);
    chk("arst_busy32_after", 32'(busy32), 0);
    issue8(2'b01, 8'h80, 8'h80, 32'h40, 32'h00, 0);
    wait_done8();
    issue8(2'b11, 8'h81, 8'h03, 32'hFF, 32'hD6, 0);
    wait_done8();
    issue8(2'b11, 8'h80, 8'hFF, 32'h00, 32'h80, 0);
    wait_done8();
    issue8(2'b10, 8'h05, 8'h00, 32'h05, 32'hFF, 1);
    wait_done8();
    issue8(2'b00, 8'hFF, 8'hFF, 32'hFE, 32'h01, 0);
    wait_done8();
    repeat (3) @(negedge clk);
    chk("q32_drained", q32.size(), 0);
    chk("q8_drained", q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
